// File: rtl/adex_pkg.sv
// ---------------------------------------------------------------------------
// adex_pkg
// Definitions shared by the AdEx parameter-load transmitter and the neuron
// loader: symbol values, frame geometry, byte positions of each parameter
// inside the 56-bit bundle, the transmitter state type and the helper that
// maps a symbol index to the nibble on the bus.
// ---------------------------------------------------------------------------
package adex_pkg;

    localparam int N_PARAMS  = 7;
    localparam int N_SYMBOLS = 16;
    localparam int BUNDLE_W  = 8 * N_PARAMS;

    localparam logic [3:0] HEADER_NIB     = 4'h0;
    localparam logic [3:0] FOOTER_NIB     = 4'hF;
    // Corrupted footer used for loader-abort testing.
    localparam logic [3:0] BAD_FOOTER_NIB = 4'hE;

    // Byte index of each parameter inside the bundle (byte k = bits [8k+7:8k]).
    localparam int IDX_DELTAT = 0;
    localparam int IDX_TAUW   = 1;
    localparam int IDX_A      = 2;
    localparam int IDX_B      = 3;
    localparam int IDX_VRESET = 4;
    localparam int IDX_VT     = 5;
    localparam int IDX_IBIAS  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SYM,
        ST_HOLD,
        ST_FIN
    } tx_state_e;

    // Data symbols 1..14 carry byte (i-1)/2, high nibble on odd i, low on even i.
    function automatic logic [3:0] data_nibble(input logic [BUNDLE_W-1:0] bundle,
                                               input logic [3:0]          idx);
        int base;
        base = ((int'(idx) - 1) / 2) * 8 + (idx[0] ? 4 : 0);
        return 4'(bundle >> base);
    endfunction

    function automatic logic [3:0] sym_value(input logic [BUNDLE_W-1:0] bundle,
                                             input logic [3:0]          idx,
                                             input logic                bad);
        if (idx == 4'd0)
            return HEADER_NIB;
        if (idx == 4'(N_SYMBOLS - 1))
            return bad ? BAD_FOOTER_NIB : FOOTER_NIB;
        return data_nibble(bundle, idx);
    endfunction

endpackage

// File: rtl/adex_strobe_timer.sv
// ---------------------------------------------------------------------------
// adex_strobe_timer
// Per-symbol phase generator: STROBE_LO cycles low, then STROBE_HI cycles
// high. The phase flop is the load_enable output of the transmitter, so it
// is a clean registered strobe.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       force idle (phase low) on the next edge
//   begin_sym   start a new symbol (low phase) on the next edge
//   run         advance the current symbol this cycle
//   phase_hi    1 during the high phase of a symbol
//   sym_end     this cycle is the last high cycle of the symbol
// ---------------------------------------------------------------------------
module adex_strobe_timer #(
    parameter int STROBE_LO = 2,
    parameter int STROBE_HI = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic begin_sym,
    input  logic run,
    output logic phase_hi,
    output logic sym_end
);

    localparam int PH_MAX = (STROBE_LO > STROBE_HI) ? STROBE_LO : STROBE_HI;
    localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [CW-1:0] LO_M1 = CW'(STROBE_LO - 1);
    localparam logic [CW-1:0] HI_M1 = CW'(STROBE_HI - 1);

    logic [CW-1:0] cnt;

    assign sym_end = run && phase_hi && (cnt == '0);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            phase_hi <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            phase_hi <= 1'b0;
        end else if (begin_sym) begin
            cnt      <= LO_M1;
            phase_hi <= 1'b0;
        end else if (run) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!phase_hi) begin
                cnt      <= HI_M1;
                phase_hi <= 1'b1;
            end else begin
                phase_hi <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adex_param_streamer.sv
// ---------------------------------------------------------------------------
// adex_param_streamer
// Host-side transmitter for the neuron parameter-load nibble protocol.
// On start it latches a 7-byte AdEx bundle and sends: SETUP cycles of
// load_mode envelope, header 0x0, 14 data nibbles (byte 0 first, high nibble
// first), footer 0xF, then HOLD cycles of envelope so the loader commits.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request, sampled only in IDLE
//   abort        cancel any transfer in progress (wins over start)
//   bad_footer   test injection, sampled with start
//   p_bundle     [7:0] DeltaT .. [55:48] Ibias
//   load_mode    frame envelope
//   load_enable  symbol strobe (receiver samples on its rising edge)
//   nibble_out   symbol data
//   busy         transfer in progress
//   done         one-cycle completion pulse
//
// Build option ADEX_TX_BAD_FOOTER_EN: when defined, bad_footer=1 sampled
// with start sends the footer as 0xE. Undefined: bad_footer is ignored.
// ---------------------------------------------------------------------------
module adex_param_streamer
    import adex_pkg::*;
#(
    parameter int STROBE_LO = 2,
    parameter int STROBE_HI = 2,
    parameter int SETUP     = 2,
    parameter int HOLD      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                bad_footer,
    input  logic [BUNDLE_W-1:0] p_bundle,
    output logic                load_mode,
    output logic                load_enable,
    output logic [3:0]          nibble_out,
    output logic                busy,
    output logic                done
);

    localparam int CNT_MAX = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] SETUP_M1 = CW'(SETUP - 1);
    localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);
    localparam logic [3:0]    LAST_SYM = 4'(N_SYMBOLS - 1);

    tx_state_e           state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [3:0]          sym_idx, idx_nxt;
    logic                bad_q, bad_nxt;
    logic                mode_nxt, busy_nxt, done_nxt;
    logic [3:0]          nib_nxt;
    logic [BUNDLE_W-1:0] shadow;
    logic                load_shadow;
    logic                t_clear, t_begin, t_run, sym_end;

`ifndef ADEX_TX_BAD_FOOTER_EN
    logic unused_bad_footer;
    assign unused_bad_footer = bad_footer;
`endif

    adex_strobe_timer #(
        .STROBE_LO (STROBE_LO),
        .STROBE_HI (STROBE_HI)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (t_clear),
        .begin_sym (t_begin),
        .run       (t_run),
        .phase_hi  (load_enable),
        .sym_end   (sym_end)
    );

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead and registered so the loader never sees combinational glitches.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = sym_idx;
        bad_nxt     = bad_q;
        mode_nxt    = load_mode;
        nib_nxt     = nibble_out;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        load_shadow = 1'b0;
        t_clear     = 1'b0;
        t_begin     = 1'b0;
        t_run       = 1'b0;

        if (state != ST_IDLE && abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            mode_nxt  = 1'b0;
            nib_nxt   = 4'h0;
            busy_nxt  = 1'b0;
            t_clear   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Abort outranks start even when idle.
                    if (start && !abort) begin
                        load_shadow = 1'b1;
                        idx_nxt     = 4'd0;
`ifdef ADEX_TX_BAD_FOOTER_EN
                        bad_nxt     = bad_footer;
`else
                        bad_nxt     = 1'b0;
`endif
                        state_nxt   = ST_ARM;
                        cnt_nxt     = SETUP_M1;
                        mode_nxt    = 1'b1;
                        busy_nxt    = 1'b1;
                        nib_nxt     = 4'h0;
                    end
                end
                ST_ARM: begin
                    if (cnt == '0) begin
                        state_nxt = ST_SYM;
                        t_begin   = 1'b1;
                        nib_nxt   = HEADER_NIB;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_SYM: begin
                    t_run = 1'b1;
                    if (sym_end) begin
                        if (sym_idx == LAST_SYM) begin
                            state_nxt = ST_HOLD;
                            cnt_nxt   = HOLD_M1;
                            nib_nxt   = 4'h0;
                            t_clear   = 1'b1;
                        end else begin
                            // Next nibble appears on its symbol's first low cycle.
                            idx_nxt = sym_idx + 4'd1;
                            nib_nxt = sym_value(shadow, sym_idx + 4'd1, bad_q);
                            t_begin = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = ST_FIN;
                        mode_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_FIN: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    mode_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    nib_nxt   = 4'h0;
                    t_clear   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sym_idx    <= 4'd0;
            bad_q      <= 1'b0;
            load_mode  <= 1'b0;
            nibble_out <= 4'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sym_idx    <= idx_nxt;
            bad_q      <= bad_nxt;
            load_mode  <= mode_nxt;
            nibble_out <= nib_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // NOTE: the shadow bundle has no reset; it is always loaded on start
    // before any symbol reads it, so a reset value would never be observed.
    always_ff @(posedge clk) begin
        if (load_shadow)
            shadow <= p_bundle;
    end

endmodule
